// File: rtl/seg_scan_driver.sv
// seg_scan_driver: double-buffered 8-digit seven-segment scanner with blanking dead-time and brightness PWM
module seg_scan_driver #(
  parameter int DIGIT_CYCLES = 12500,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic [55:0] frame,
  input  logic        frame_valid,
  output logic        frame_ready,
  input  logic [2:0]  bright,
  output logic [7:0]  AN,
  output logic [6:0]  A2G,
  output logic        frame_done
);
  localparam int SLICE = (DIGIT_CYCLES - BLANK_CYCLES) / 8;
  localparam int CW = $clog2(DIGIT_CYCLES);
  logic [55:0]   pend_q, pend_d, disp_q, disp_d;
  logic          pend_full_q, pend_full_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    dig_q, dig_d, br_q, br_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    a2g_q, a2g_d;
  logic          done_q, done_d;
  logic          wrap, bnd, acc, lit;
  logic [31:0]   lit_end;
  // Scan counters, frame buffering and phase decode; pin values are registered one cycle behind the decode
  always_comb begin
    wrap        = cnt_q == CW'(DIGIT_CYCLES - 1);
    bnd         = wrap && dig_q == 3'd7;
    acc         = frame_valid && !pend_full_q;
    lit_end     = 32'(BLANK_CYCLES) + (32'(br_q) + 32'd1) * 32'(SLICE);
    lit         = 32'(cnt_q) >= 32'(BLANK_CYCLES) && 32'(cnt_q) < lit_end;
    cnt_d       = wrap ? '0 : cnt_q + 1'b1;
    dig_d       = wrap ? dig_q + 3'd1 : dig_q;
    br_d        = cnt_q == '0 ? bright : br_q;
    pend_d      = acc ? frame : pend_q;
    pend_full_d = acc ? 1'b1 : (bnd ? 1'b0 : pend_full_q);
    disp_d      = (bnd && pend_full_q) ? pend_q : disp_q;
    an_d        = lit ? ~(8'b1 << dig_q) : 8'hFF;
    a2g_d       = lit ? disp_q[7*dig_q +: 7] : 7'h7F;
    done_d      = bnd;
  end
  // State registers; reset blanks the display and discards any pending frame
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      disp_q      <= '1;
      cnt_q       <= '0;
      dig_q       <= '0;
      br_q        <= '0;
      an_q        <= 8'hFF;
      a2g_q       <= 7'h7F;
      done_q      <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      disp_q      <= disp_d;
      cnt_q       <= cnt_d;
      dig_q       <= dig_d;
      br_q        <= br_d;
      an_q        <= an_d;
      a2g_q       <= a2g_d;
      done_q      <= done_d;
    end
  end
  assign frame_ready = ~pend_full_q;
  assign AN          = an_q;
  assign A2G         = a2g_q;
  assign frame_done  = done_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed checks of scanning, brightness, handshake and reset with a pin invariant monitor
module tb_seg_scan_driver;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [55:0] frame = '0;
  logic        frame_valid = 1'b0;
  logic        frame_ready;
  logic [2:0]  bright = 3'd7;
  logic [7:0]  an;
  logic [6:0]  a2g;
  logic        frame_done;
  int errors = 0;
  int checks = 0;
  int k = 0;
  int run = 0;
  logic [7:0] last_an = 8'hFF;
  logic mon_en = 1'b0;
  seg_scan_driver #(.DIGIT_CYCLES(20), .BLANK_CYCLES(4)) dut (
    .CLK100MHZ(clk), .CPU_RESETN(rst_n), .frame(frame), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .bright(bright), .AN(an), .A2G(a2g), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    k++;
    @(negedge clk);
  endtask
  task automatic go(input int t);
    if (t < k) chk("go_order", 64'(k), 64'(t));
    while (k < t) tick();
  endtask
  function automatic logic [55:0] mk(input logic [6:0] base);
    logic [55:0] f;
    for (int i = 0; i < 8; i++) f[7*i +: 7] = base | 7'(i);
    return f;
  endfunction
  // Anodes one-hot-or-idle every cycle, and at least 4 idle cycles before any digit change
  always @(negedge clk) if (mon_en) begin
    chk("onehot", 64'($countones(~an) <= 1), 64'd1);
    if (an == 8'hFF) run++;
    else begin
      if (an != last_an) chk("blank_gap", 64'(run >= 4), 64'd1);
      last_an = an;
      run = 0;
    end
  end
  initial begin
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    chk("rst_an", an, 8'hFF);
    chk("rst_a2g", a2g, 7'h7F);
    chk("rst_ready", frame_ready, 1);
    chk("rst_done", frame_done, 0);
    rst_n = 1'b1;
    k = 0;
    go(4);   chk("f0d0_blank", an, 8'hFF);
    go(5);   chk("f0d0_an", an, 8'hFE); chk("f0d0_a2g", a2g, 7'h7F);
    go(71);  chk("f0d3_an", an, 8'hF7); chk("f0d3_a2g", a2g, 7'h7F);
    go(159); chk("done_pre", frame_done, 0);
    go(160); chk("f0d7_an", an, 8'h7F); chk("done1", frame_done, 1);
    go(161); chk("done_post", frame_done, 0);
    go(320); chk("done2", frame_done, 1);
    go(330);
    chk("ready_pre", frame_ready, 1);
    frame = mk(7'h40); frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0; frame = '0;
    chk("ready_drop", frame_ready, 0);
    go(471); chk("f2_still_blank", a2g, 7'h7F);
    go(479); chk("ready_held", frame_ready, 0);
    go(480); chk("ready_rise", frame_ready, 1);
    go(484); chk("f3d0_blank", an, 8'hFF);
    go(485); chk("f3d0_an", an, 8'hFE); chk("f3d0_a2g", a2g, 7'h40);
    go(500); chk("f3d0_end_an", an, 8'hFE); chk("f3d0_end_a2g", a2g, 7'h40);
    go(585); chk("f3d5_an", an, 8'hDF); chk("f3d5_a2g", a2g, 7'h45);
    go(631); chk("f3d7_an", an, 8'h7F); chk("f3d7_a2g", a2g, 7'h47);
    go(641); bright = 3'd0;
    go(844); chk("min_blank", an, 8'hFF);
    go(845); chk("min_lit0", an, 8'hFB); chk("min_a2g", a2g, 7'h42);
    go(846); chk("min_lit1", an, 8'hFB);
    go(847); chk("min_dark", an, 8'hFF); chk("min_dark_a2g", a2g, 7'h7F);
    go(860); chk("min_dark_end", an, 8'hFF);
    go(963); bright = 3'd3;
    go(966); chk("mid_old_lit", an, 8'hFE);
    go(967); chk("mid_old_dark", an, 8'hFF);
    go(992); chk("mid_new_lit", an, 8'hFD);
    go(993); chk("mid_new_dark", an, 8'hFF);
    bright = 3'd7;
    go(1185);
    chk("a_ready", frame_ready, 1);
    frame = mk(7'h20); frame_valid = 1'b1;
    tick();
    chk("a_taken", frame_ready, 0);
    frame = mk(7'h30);
    go(1279); chk("b_blocked", frame_ready, 0);
    go(1280); chk("b_ready", frame_ready, 1);
    tick();
    frame_valid = 1'b0; frame = '0;
    chk("b_taken", frame_ready, 0);
    go(1285); chk("a_d0", a2g, 7'h20);
    go(1351); chk("a_d3_an", an, 8'hF7); chk("a_d3_a2g", a2g, 7'h23);
    go(1431); chk("a_d7", a2g, 7'h27);
    go(1450);
    chk("c_ready", frame_ready, 1);
    frame = mk(7'h00); frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0; frame = '0;
    chk("c_taken", frame_ready, 0);
    go(1485); chk("b_d2_an", an, 8'hFB); chk("b_d2_a2g", a2g, 7'h32);
    go(1551); chk("pre_rst_an", an, 8'hDF); chk("pre_rst_a2g", a2g, 7'h35);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_an", an, 8'hFF);
    chk("mid_rst_a2g", a2g, 7'h7F);
    chk("mid_rst_ready", frame_ready, 1);
    chk("mid_rst_done", frame_done, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    go(5);   chk("post_d0_an", an, 8'hFE); chk("post_d0_a2g", a2g, 7'h7F);
    go(160); chk("post_done", frame_done, 1);
    go(165); chk("post_f1d0_a2g", a2g, 7'h7F);
    go(200); chk("post_ready", frame_ready, 1);
    go(271); chk("post_f1d5_an", an, 8'hDF); chk("post_f1d5_a2g", a2g, 7'h7F);
    go(1600); chk("end_ready", frame_ready, 1);
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
